cluster_tile_pwr_seq: RTL



---
 rtl/cluster_tile_pwr_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cluster_tile_pwr_seq.sv
// Per-tile clock-enable / reset sequencer with idle-drain on power-off.
// Optional drain timeout enabled by defining PB_TILE_PWR_DRAIN_TIMEOUT_EN.
module cluster_tile_pwr_seq #(
    parameter int RstCycles     = 8,
    parameter int SettleCycles  = 4,
    parameter int IdleCycles    = 16,
    parameter int TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cmd_valid_i,
    input  logic cmd_on_i,
    output logic cmd_ready_o,
    input  logic tile_idle_i,
    input  logic timeout_clr_i,
    output logic tile_clk_en_o,
    output logic tile_rst_no,
    output logic tile_on_o,
    output logic busy_o,
    output logic timeout_o
);

    typedef enum logic [2:0] {
        OFF, ON_RST, ON_SETTLE, ON, OFF_DRAIN, OFF_RST
    } state_t;

    localparam int MaxA = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int MaxB = (MaxA > IdleCycles) ? MaxA : IdleCycles;
`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
    localparam int MaxP = (MaxB > TimeoutCycles) ? MaxB : TimeoutCycles;
`else
    localparam int MaxP = MaxB;
`endif
    localparam int CW = $clog2(MaxP) + 1;

    localparam logic [CW-1:0] RstLd  = CW'(RstCycles - 1);
    localparam logic [CW-1:0] SetLd  = CW'(SettleCycles - 1);
    localparam logic [CW-1:0] IdleLd = CW'(IdleCycles - 1);

    // Output vector order: clk_en, rst_n, on, busy, ready
    function automatic logic [4:0] outs(input state_t s);
        logic [4:0] v;
        v = 5'b00001;
        unique case (s)
            OFF:       v = 5'b00001;
            ON_RST:    v = 5'b10010;
            ON_SETTLE: v = 5'b11010;
            ON:        v = 5'b11101;
            OFF_DRAIN: v = 5'b11010;
            OFF_RST:   v = 5'b10010;
            default:   v = 5'b00001;
        endcase
        return v;
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    o;

    assign {tile_clk_en_o, tile_rst_no, tile_on_o, busy_o, cmd_ready_o} = o;

`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
    localparam logic [CW-1:0] TmoLd = CW'(TimeoutCycles - 1);
    logic [CW-1:0] tcnt;
    logic          to_q;
    assign timeout_o = to_q;
`else
    logic unused_tmo;
    assign unused_tmo = timeout_clr_i ^ (TimeoutCycles > 0);
    assign timeout_o  = 1'b0;
`endif

    // Sequencer FSM; outputs are registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= OFF;
            cnt   <= '0;
            o     <= outs(OFF);
`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
            tcnt  <= '0;
            to_q  <= 1'b0;
`endif
        end else begin
`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
            if (timeout_clr_i) to_q <= 1'b0;
`endif
            unique case (state)
                OFF: begin
                    if (cmd_valid_i && cmd_on_i) begin
                        state <= ON_RST;
                        cnt   <= RstLd;
                        o     <= outs(ON_RST);
                    end
                end
                ON_RST: begin
                    if (cnt == '0) begin
                        state <= ON_SETTLE;
                        cnt   <= SetLd;
                        o     <= outs(ON_SETTLE);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ON_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ON;
                        o     <= outs(ON);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ON: begin
                    if (cmd_valid_i && !cmd_on_i) begin
                        state <= OFF_DRAIN;
                        cnt   <= IdleLd;
                        o     <= outs(OFF_DRAIN);
`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
                        tcnt  <= TmoLd;
`endif
                    end
                end
                OFF_DRAIN: begin
`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
                    tcnt <= tcnt - 1'b1;
`endif
                    if (tile_idle_i && cnt == '0) begin
                        state <= OFF_RST;
                        cnt   <= RstLd;
                        o     <= outs(OFF_RST);
`ifdef PB_TILE_PWR_DRAIN_TIMEOUT_EN
                    end else if (tcnt == '0) begin
                        state <= OFF_RST;
                        cnt   <= RstLd;
                        o     <= outs(OFF_RST);
                        to_q  <= 1'b1;
`endif
                    end else if (!tile_idle_i) begin
                        cnt <= IdleLd;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OFF_RST: begin
                    if (cnt == '0) begin
                        state <= OFF;
                        o     <= outs(OFF);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= OFF;
                    o     <= outs(OFF);
                end
            endcase
        end
    end

endmodule
